// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst engine and its burst buffer.
package dma_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_BASE,
        S_DESC_AR,
        S_DESC_R,
        S_XFER_AR,
        S_XFER_R,
        S_XFER_AW,
        S_XFER_W,
        S_XFER_B,
        S_DONE
    } dma_state_e;

    typedef enum logic [3:0] {
        SEL_NONE = 4'd0,
        SEL_SRC  = 4'd1,
        SEL_DST  = 4'd2,
        SEL_LEN  = 4'd3,
        SEL_NEXT = 4'd4,
        SEL_EOC  = 4'd5
    } desc_sel_e;

    localparam int unsigned DESC_WORDS = 5;

    // Descriptor beat k (0-based) lands in register-block field k+1.
    function automatic desc_sel_e beat_sel(input logic [2:0] k);
        return desc_sel_e'(4'(k) + 4'd1);
    endfunction

endpackage

// File: rtl/dma_burst_buf.sv
// Store-and-forward buffer for one burst: 2**LEN_W entries, separate write and read pointers.
module dma_burst_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [LEN_W-1:0]  o_wr_ptr,
    output logic [LEN_W-1:0]  o_rd_ptr
);
    localparam int unsigned DEPTH = 2**LEN_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LEN_W-1:0]  r_wr_ptr;
    logic [LEN_W-1:0]  r_rd_ptr;

    // Pointer update; clear has priority so a new burst always starts at entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Data storage; contents are don't-care until written so no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/dma_burst_engine.sv
// DMA sequencing engine: loads descriptors into the register block over AXI read, then
// moves data in store-and-forward bursts, following descriptor chains until end-of-chain.
module dma_burst_engine
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DMAEN,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic              isDMA_en,
    input  logic [ADDR_W-1:0] SrcAddr_perBurst,
    input  logic [ADDR_W-1:0] DstAddr_perBurst,
    input  logic [LEN_W-1:0]  TransSize,
    input  logic              EOT,
    output logic [DATA_W-1:0] DESC_input,
    output logic [3:0]        sel,
    output logic              EOB,
    output logic              isTransferring,
    output logic              busy,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [LEN_W-1:0]  AWLEN,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic              BVALID,
    output logic              BREADY
);
    dma_state_e        r_state;
    dma_state_e        w_next;
    logic              r_dmaen_q;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len_q;
    logic              r_eot_q;
    logic              r_eoc_q;
    logic [2:0]        r_dbeat;

    logic              w_rise;
    logic              w_keep;
    logic              w_desc_last;
    logic              w_buf_wr;
    logic              w_buf_rd;
    logic              w_buf_clr;
    logic [DATA_W-1:0] w_rd_data;
    logic [LEN_W-1:0]  w_wr_ptr;
    logic [LEN_W-1:0]  w_rd_ptr;

    assign w_rise      = DMAEN & ~r_dmaen_q;
    assign w_keep      = DMAEN & isDMA_en;
    assign w_desc_last = (r_dbeat == 3'(DESC_WORDS - 1));
    assign w_buf_wr    = (r_state == S_XFER_R) & RVALID;
    assign w_buf_rd    = (r_state == S_XFER_W) & WREADY;
    assign w_buf_clr   = ((r_state == S_XFER_B) & BVALID) | (r_state == S_IDLE);

    dma_burst_buf #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_buf_clr),
        .i_wr_en   (w_buf_wr),
        .i_wr_data (RDATA),
        .i_rd_en   (w_buf_rd),
        .o_rd_data (w_rd_data),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_ptr  (w_rd_ptr)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; enable loss is honoured only at burst/descriptor boundaries.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_rise) w_next = S_LOAD_BASE;
            S_LOAD_BASE: w_next = S_DESC_AR;
            S_DESC_AR:   if (ARREADY) w_next = S_DESC_R;
            S_DESC_R: begin
                if (RVALID) begin
                    if (w_desc_last) begin
                        if (!RLAST)      w_next = S_DONE;
                        else if (w_keep) w_next = S_XFER_AR;
                        else             w_next = S_IDLE;
                    end else if (RLAST) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_XFER_AR:   if (ARREADY) w_next = S_XFER_R;
            S_XFER_R:    if (RVALID && RLAST) w_next = S_XFER_AW;
            S_XFER_AW:   if (AWREADY) w_next = S_XFER_W;
            S_XFER_W:    if (WREADY && WLAST) w_next = S_XFER_B;
            S_XFER_B: begin
                if (BVALID) begin
                    if (!w_keep)       w_next = S_IDLE;
                    else if (!r_eot_q) w_next = S_XFER_AR;
                    else if (!r_eoc_q) w_next = S_DESC_AR;
                    else               w_next = S_DONE;
                end
            end
            S_DONE:      if (!DMAEN) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Datapath registers: enable edge detect, base address, burst length and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dmaen_q <= 1'b0;
            r_base    <= '0;
            r_len_q   <= '0;
            r_eot_q   <= 1'b0;
            r_eoc_q   <= 1'b0;
            r_dbeat   <= '0;
        end else begin
            r_dmaen_q <= DMAEN;
            if (r_state == S_IDLE && w_rise) r_base <= desc_base;
            if (r_state == S_DESC_AR) r_dbeat <= '0;
            if (r_state == S_DESC_R && RVALID) begin
                r_dbeat <= r_dbeat + 3'd1;
                if (w_desc_last) r_eoc_q <= RDATA[0];
            end
            if (r_state == S_XFER_AR && ARREADY) begin
                r_len_q <= TransSize;
                r_eot_q <= EOT;
            end
            // The write burst mirrors what actually arrived, even if RLAST disagrees with ARLEN.
            if (r_state == S_XFER_R && RVALID && RLAST) r_len_q <= w_wr_ptr;
        end
    end

    // Output decode from state; VALIDs depend only on state, never on READY.
    always_comb begin
        DESC_input     = '0;
        sel            = SEL_NONE;
        EOB            = 1'b0;
        isTransferring = 1'b0;
        busy           = (r_state != S_IDLE);
        ARADDR         = '0;
        ARLEN          = '0;
        ARVALID        = 1'b0;
        RREADY         = 1'b0;
        AWADDR         = '0;
        AWLEN          = '0;
        AWVALID        = 1'b0;
        WDATA          = '0;
        WLAST          = 1'b0;
        WVALID         = 1'b0;
        BREADY         = 1'b0;
        case (r_state)
            S_LOAD_BASE: begin
                sel        = SEL_NEXT;
                DESC_input = r_base;
            end
            S_DESC_AR: begin
                ARVALID = 1'b1;
                ARADDR  = SrcAddr_perBurst;
                ARLEN   = LEN_W'(DESC_WORDS - 1);
            end
            S_DESC_R: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    DESC_input = RDATA;
                    sel        = beat_sel(r_dbeat);
                end
            end
            S_XFER_AR: begin
                isTransferring = 1'b1;
                ARVALID        = 1'b1;
                ARADDR         = SrcAddr_perBurst;
                ARLEN          = TransSize;
            end
            S_XFER_R: begin
                isTransferring = 1'b1;
                RREADY         = 1'b1;
            end
            S_XFER_AW: begin
                isTransferring = 1'b1;
                AWVALID        = 1'b1;
                AWADDR         = DstAddr_perBurst;
                AWLEN          = r_len_q;
            end
            S_XFER_W: begin
                isTransferring = 1'b1;
                WVALID         = 1'b1;
                WDATA          = w_rd_data;
                WLAST          = (w_rd_ptr == r_len_q);
            end
            S_XFER_B: begin
                isTransferring = 1'b1;
                BREADY         = 1'b1;
                EOB            = BVALID;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_burst_engine.sv
// Self-checking bench for dma_burst_engine: register-block model, AXI slave models and a write-data scoreboard.
module tb_dma_burst_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        DMAEN;
    logic [31:0] desc_base;
    logic        isDMA_en;
    logic [31:0] SrcAddr_perBurst, DstAddr_perBurst;
    logic [3:0]  TransSize;
    logic        EOT;
    logic [31:0] DESC_input;
    logic [3:0]  sel;
    logic        EOB, isTransferring, busy;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic        RLAST, RVALID, RREADY;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic        WLAST, WVALID, WREADY;
    logic        BVALID, BREADY;

    always #5 clk = ~clk;

    dma_burst_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .DMAEN(DMAEN), .desc_base(desc_base), .isDMA_en(isDMA_en),
        .SrcAddr_perBurst(SrcAddr_perBurst), .DstAddr_perBurst(DstAddr_perBurst),
        .TransSize(TransSize), .EOT(EOT), .DESC_input(DESC_input), .sel(sel), .EOB(EOB),
        .isTransferring(isTransferring), .busy(busy),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct packed { logic [31:0] addr; logic [3:0] len; } req_t;
    typedef struct {
        logic [31:0] len;
        int          stall;
        int          nb;
        logic [3:0]  arlen [4];
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Register-block model: bursts of up to 16 beats, addresses advance by 15 per burst.
    logic [31:0] m_src, m_dst, m_rem, m_dptr;
    assign SrcAddr_perBurst = isTransferring ? m_src : m_dptr;
    assign DstAddr_perBurst = m_dst;
    assign TransSize        = (m_rem > 32'd15) ? 4'd15 : m_rem[3:0];
    assign EOT              = (m_rem <= 32'd15);
    assign isDMA_en         = DMAEN;

    logic [31:0] dmem [logic [31:0]];
    req_t        rq[$];
    logic [32:0] sb[$];
    req_t        ar_log[$], aw_log[$], exp_ar[$], exp_aw[$];
    logic [35:0] sel_log[$], exp_sel[$];
    int          r_beat, pend_b, eob_cnt, viol, gaps, gap_nb, stall_pct;
    bit          r_hs, b_hs, sel_pend, eob_pend, xfer_seen;
    logic [3:0]  pend_sel;
    logic [31:0] pend_data;
    bit          prev_arw, prev_aww, prev_ww, prev_eob;
    req_t        prev_ar, prev_aw;
    logic [32:0] prev_w;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave models and monitor: drive on negedge, sample 1 ns later; state effects land at the next negedge.
    always @(negedge clk) begin
        if (rst) begin
            ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0;
            AWREADY = 0; WREADY = 0; BVALID = 0;
            rq.delete(); sb.delete();
            r_beat = 0; pend_b = 0; r_hs = 0; b_hs = 0; sel_pend = 0; eob_pend = 0;
            prev_arw = 0; prev_aww = 0; prev_ww = 0; prev_eob = 0;
        end else begin
            if (r_hs) begin RVALID = 0; r_hs = 0; end
            if (b_hs) begin BVALID = 0; pend_b--; b_hs = 0; end
            if (sel_pend) begin
                case (pend_sel)
                    4'd1: m_src = pend_data;
                    4'd2: m_dst = pend_data;
                    4'd3: m_rem = pend_data;
                    4'd4: m_dptr = pend_data;
                    default: ;
                endcase
                sel_pend = 0;
            end
            if (eob_pend) begin
                m_src = m_src + 15; m_dst = m_dst + 15;
                m_rem = (m_rem > 15) ? m_rem - 15 : 0;
                eob_pend = 0;
            end
            ARREADY = ($urandom_range(99) >= stall_pct);
            AWREADY = ($urandom_range(99) >= stall_pct);
            WREADY  = ($urandom_range(99) >= stall_pct);
            if (!RVALID && rq.size() > 0 && $urandom_range(99) >= stall_pct) begin
                RVALID = 1;
                RDATA  = mem_rd(rq[0].addr + r_beat);
                RLAST  = (r_beat == int'(rq[0].len));
            end
            if (!BVALID && pend_b > 0 && $urandom_range(99) >= stall_pct) BVALID = 1;
            #1;
            if (prev_arw && (!ARVALID || {ARADDR, ARLEN} !== prev_ar)) viol++;
            if (prev_aww && (!AWVALID || {AWADDR, AWLEN} !== prev_aw)) viol++;
            if (prev_ww && (!WVALID || {WLAST, WDATA} !== prev_w)) viol++;
            if (prev_eob && EOB) viol++;
            if (ARVALID && ARREADY) begin
                ar_log.push_back({ARADDR, ARLEN});
                rq.push_back({ARADDR, ARLEN});
            end
            if (RVALID && RREADY) begin
                if (isTransferring) sb.push_back({RLAST, RDATA});
                if (RLAST) begin void'(rq.pop_front()); r_beat = 0; end
                else r_beat++;
                r_hs = 1;
            end
            if (AWVALID && AWREADY) aw_log.push_back({AWADDR, AWLEN});
            if (WVALID && WREADY) begin
                if (sb.size() == 0) chk("w_unexpected", {WLAST, WDATA}, 33'h0);
                else chk("wbeat", {WLAST, WDATA}, sb.pop_front());
                if (WLAST) pend_b++;
            end
            if (sel != 4'd0) begin
                sel_log.push_back({sel, DESC_input});
                sel_pend = 1; pend_sel = sel; pend_data = DESC_input;
            end
            if (EOB) begin eob_cnt++; eob_pend = 1; end
            if (BVALID && BREADY) b_hs = 1;
            if (isTransferring) xfer_seen = 1;
            if (busy && xfer_seen && !isTransferring && eob_cnt < gap_nb) gaps++;
            prev_arw = ARVALID && !ARREADY; prev_ar = {ARADDR, ARLEN};
            prev_aww = AWVALID && !AWREADY; prev_aw = {AWADDR, AWLEN};
            prev_ww  = WVALID && !WREADY;   prev_w  = {WLAST, WDATA};
            prev_eob = EOB;
        end
    end

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); sel_log.delete();
        exp_ar.delete(); exp_aw.delete(); exp_sel.delete();
        eob_cnt = 0; viol = 0; gaps = 0; gap_nb = 0; xfer_seen = 0;
    endtask

    task automatic load_desc(input logic [31:0] at, s, d, l, nx, e);
        dmem[at] = s; dmem[at+1] = d; dmem[at+2] = l; dmem[at+3] = nx; dmem[at+4] = e;
        exp_sel.push_back({4'd1, s}); exp_sel.push_back({4'd2, d}); exp_sel.push_back({4'd3, l});
        exp_sel.push_back({4'd4, nx}); exp_sel.push_back({4'd5, e});
    endtask

    task automatic wait_eob(input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #2;
            if (eob_cnt >= n) begin ok = 1; break; end
        end
    endtask

    task automatic run_check(input string nm, input int nb, input bit gap_chk);
        bit ok;
        gap_nb = gap_chk ? nb : 0;
        DMAEN = 1;
        wait_eob(nb, ok);
        chk($sformatf("%s_timeout", nm), 64'(ok), 64'd1);
        repeat (4) @(negedge clk);
        #2;
        chk($sformatf("%s_done_busy", nm), {63'd0, busy}, 64'd1);
        chk($sformatf("%s_done_arvalid", nm), {63'd0, ARVALID}, 64'd0);
        DMAEN = 0;
        repeat (2) @(negedge clk);
        #2;
        chk($sformatf("%s_idle_busy", nm), {63'd0, busy}, 64'd0);
        chk($sformatf("%s_eob", nm), 64'(eob_cnt), 64'(nb));
        chk($sformatf("%s_ar_n", nm), 64'(ar_log.size()), 64'(exp_ar.size()));
        for (int k = 0; k < exp_ar.size() && k < ar_log.size(); k++)
            chk($sformatf("%s_ar%0d", nm, k), 64'(ar_log[k]), 64'(exp_ar[k]));
        chk($sformatf("%s_aw_n", nm), 64'(aw_log.size()), 64'(exp_aw.size()));
        for (int k = 0; k < exp_aw.size() && k < aw_log.size(); k++)
            chk($sformatf("%s_aw%0d", nm, k), 64'(aw_log[k]), 64'(exp_aw[k]));
        chk($sformatf("%s_sel_n", nm), 64'(sel_log.size()), 64'(exp_sel.size()));
        for (int k = 0; k < exp_sel.size() && k < sel_log.size(); k++)
            chk($sformatf("%s_sel%0d", nm, k), 64'(sel_log[k]), 64'(exp_sel[k]));
        chk($sformatf("%s_sb_left", nm), 64'(sb.size()), 64'd0);
        chk($sformatf("%s_stable", nm), 64'(viol), 64'd0);
        if (gap_chk) chk($sformatf("%s_xfer_gap", nm), 64'(gaps), 64'd0);
    endtask

    vec_t vecs [5];

    task automatic run_vec(input int i);
        logic [31:0] s, d;
        clear_logs();
        stall_pct = vecs[i].stall;
        s = 32'h1000 + 32'(i) * 32'h100;
        d = 32'h2000 + 32'(i) * 32'h100;
        desc_base = 32'h100;
        exp_sel.push_back({4'd4, 32'h100});
        load_desc(32'h100, s, d, vecs[i].len, 32'h0, 32'h1);
        exp_ar.push_back({32'h100, 4'd4});
        for (int b = 0; b < vecs[i].nb; b++) begin
            exp_ar.push_back({s + 32'(15 * b), vecs[i].arlen[b]});
            exp_aw.push_back({d + 32'(15 * b), vecs[i].arlen[b]});
        end
        run_check($sformatf("v%0d", i), vecs[i].nb, 1'b1);
    endtask

    logic [20:0] ctrl;
    assign ctrl = {ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY, EOB, isTransferring, busy, sel, ARLEN, AWLEN};

    initial begin
        bit ok;
        vecs[0] = '{32'd8,  0,  1, '{4'd8,  4'd0,  4'd0,  4'd0}};
        vecs[1] = '{32'd40, 50, 3, '{4'd15, 4'd15, 4'd10, 4'd0}};
        vecs[2] = '{32'd0,  0,  1, '{4'd0,  4'd0,  4'd0,  4'd0}};
        vecs[3] = '{32'd16, 30, 2, '{4'd15, 4'd1,  4'd0,  4'd0}};
        vecs[4] = '{32'd30, 50, 2, '{4'd15, 4'd15, 4'd0,  4'd0}};
        m_src = '0; m_dst = '0; m_rem = '0; m_dptr = '0;
        rst = 1; DMAEN = 0; desc_base = '0; stall_pct = 0;
        clear_logs();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ctrl", 64'(ctrl), 64'd0);
        chk("rst_addr", {ARADDR, AWADDR}, 64'd0);
        chk("rst_data", {DESC_input, WDATA}, 64'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Two-descriptor chain: A (EOC=0, NEXT=0x200) then B (EOC=1).
        clear_logs();
        stall_pct = 20;
        desc_base = 32'h100;
        exp_sel.push_back({4'd4, 32'h100});
        load_desc(32'h100, 32'h3000, 32'h4000, 32'd5, 32'h200, 32'h0);
        load_desc(32'h200, 32'h5000, 32'h6000, 32'd3, 32'h0,   32'h1);
        exp_ar.push_back({32'h100, 4'd4}); exp_ar.push_back({32'h3000, 4'd5});
        exp_ar.push_back({32'h200, 4'd4}); exp_ar.push_back({32'h5000, 4'd3});
        exp_aw.push_back({32'h4000, 4'd5}); exp_aw.push_back({32'h6000, 4'd3});
        run_check("chain", 2, 1'b0);

        // Enable dropped after the first data AR: that burst finishes, then back to idle.
        clear_logs();
        stall_pct = 0;
        desc_base = 32'h100;
        load_desc(32'h100, 32'h7000, 32'h8000, 32'd40, 32'h0, 32'h1);
        DMAEN = 1;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #2;
            if (ar_log.size() >= 2) begin ok = 1; break; end
        end
        chk("abort_ar_seen", 64'(ok), 64'd1);
        DMAEN = 0;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #2;
            if (!busy) begin ok = 1; break; end
        end
        chk("abort_idle", 64'(ok), 64'd1);
        chk("abort_eob", 64'(eob_cnt), 64'd1);
        chk("abort_ar_n", 64'(ar_log.size()), 64'd2);
        chk("abort_aw_n", 64'(aw_log.size()), 64'd1);
        chk("abort_sb_left", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a write burst.
        clear_logs();
        load_desc(32'h100, 32'h7000, 32'h8000, 32'd40, 32'h0, 32'h1);
        DMAEN = 1;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #2;
            if (WVALID) begin ok = 1; break; end
        end
        chk("rstw_reach_w", 64'(ok), 64'd1);
        #1;
        rst = 1;
        #1;
        chk("rstw_ctrl", 64'(ctrl), 64'd0);
        chk("rstw_addr", {ARADDR, AWADDR}, 64'd0);
        chk("rstw_data", {DESC_input, WDATA}, 64'd0);
        DMAEN = 0;
        repeat (2) @(negedge clk);
        #2;
        rst = 0;
        repeat (2) @(negedge clk);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
